occ_level_selector: RTL

Parametrised successor to the switch-to-occupancy converter in the hit-simulator datapath. It takes N_SW raw board switches and a sweep-enable switch, then synchronises and debounces the switches. It outputs a registered occupancy value chosen from a parameter level table by lowest-index priority. An autonomous sweep mode steps through all table entries for soak testing. The output feeds the hit generator's occupancy input, and a change strobe lets downstream logic re-arm on every new value.

---
 rtl/occ_level_selector_if.sv | 32 +++
 rtl/occ_level_selector.sv | 139 +++++++++++++
 2 files changed

// File: rtl/occ_level_selector_if.sv
// rtl/occ_level_selector_if.sv - switch inputs and occupancy outputs of occ_level_selector
//
// Purpose: groups the raw switch inputs and the registered occupancy outputs.
// Ports (signals):
//   sw_in       N_SW      raw switch levels, asynchronous to clk
//   sweep_en    1         raw sweep-mode switch, asynchronous to clk
//   occ_out     OUT_SIZE  selected occupancy, registered
//   occ_idx     IDX_W     selected table index (N_SW means default level)
//   occ_changed 1         one-cycle pulse when occ_out takes a new value
// Modports: master drives the switches, slave (the selector) drives occupancy.
interface occ_level_selector_if #(
  parameter int N_SW     = 4,
  parameter int OUT_SIZE = 7
);
  localparam int IDX_W = $clog2(N_SW + 1);

  logic [N_SW-1:0]     sw_in;
  logic                sweep_en;
  logic [OUT_SIZE-1:0] occ_out;
  logic [IDX_W-1:0]    occ_idx;
  logic                occ_changed;

  modport master (
    output sw_in, sweep_en,
    input  occ_out, occ_idx, occ_changed
  );

  modport slave (
    input  sw_in, sweep_en,
    output occ_out, occ_idx, occ_changed
  );
endinterface

// File: rtl/occ_level_selector.sv
// rtl/occ_level_selector.sv - debounced switch to occupancy level selector with sweep mode
//
// Purpose: synchronises and debounces N_SW switches, picks an occupancy level
// from LEVELS by lowest-index priority (DEFAULT_LEVEL when none is set), or
// steps through every entry when the sweep switch is on.
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous reset, active-high
//   bus  slave modport of occ_level_selector_if (sw_in, sweep_en in;
//        occ_out, occ_idx, occ_changed out)
module occ_level_selector #(
  parameter int                       N_SW            = 4,
  parameter int                       OUT_SIZE        = 7,
  parameter logic [N_SW*OUT_SIZE-1:0] LEVELS          = {7'd64, 7'd32, 7'd32, 7'd1},
  parameter int                       DEFAULT_LEVEL   = 121,
  parameter int                       DEBOUNCE_CYCLES = 4,
  parameter int                       SWEEP_PERIOD    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  occ_level_selector_if.slave  bus
);
  localparam int IDX_W = $clog2(N_SW + 1);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SP_W  = $clog2(SWEEP_PERIOD + 1);
  // An oversized default is truncated to the output width.
  localparam logic [OUT_SIZE-1:0] DEF_LVL = OUT_SIZE'(DEFAULT_LEVEL);

  logic [N_SW-1:0]     r_sw_s1;
  logic [N_SW-1:0]     r_sw_s2;
  logic [N_SW-1:0]     r_sw_db;
  logic [DB_W-1:0]     r_db_cnt [N_SW];
  logic                r_sweep_s1;
  logic                r_sweep_s2;
  logic [SP_W-1:0]     r_sweep_cnt;
  logic [IDX_W-1:0]    r_sweep_idx;
  logic [OUT_SIZE-1:0] r_occ_out;
  logic [IDX_W-1:0]    r_occ_idx;
  logic                r_occ_changed;

  logic [OUT_SIZE-1:0] w_level [N_SW];
  logic [OUT_SIZE-1:0] w_sel_lvl;
  logic [IDX_W-1:0]    w_sel_idx;

  for (genvar g = 0; g < N_SW; g++) begin : g_level
    assign w_level[g] = LEVELS[g*OUT_SIZE +: OUT_SIZE];
  end

  // Two-flop synchronisers; sweep_en is used straight after synchronisation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_s1    <= '0;
      r_sw_s2    <= '0;
      r_sweep_s1 <= 1'b0;
      r_sweep_s2 <= 1'b0;
    end else begin
      r_sw_s1    <= bus.sw_in;
      r_sw_s2    <= r_sw_s1;
      r_sweep_s1 <= bus.sweep_en;
      r_sweep_s2 <= r_sweep_s1;
    end
  end

  // Per-bit debounce: a change is accepted only after DEBOUNCE_CYCLES
  // consecutive synced cycles that disagree with the debounced state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_db <= '0;
      for (int i = 0; i < N_SW; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_SW; i++) begin
        if (r_sw_s2[i] == r_sw_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          r_sw_db[i]  <= r_sw_s2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Sweep stepping. Holding index and counter at zero outside sweep mode
  // means the first sweep cycle always starts from entry 0 with a fresh period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sweep_cnt <= '0;
      r_sweep_idx <= '0;
    end else if (!r_sweep_s2) begin
      r_sweep_cnt <= '0;
      r_sweep_idx <= '0;
    end else if (r_sweep_cnt == SP_W'(SWEEP_PERIOD - 1)) begin
      r_sweep_cnt <= '0;
      r_sweep_idx <= (r_sweep_idx == IDX_W'(N_SW)) ? '0 : r_sweep_idx + 1'b1;
    end else begin
      r_sweep_cnt <= r_sweep_cnt + 1'b1;
    end
  end

  // Selection: sweep index wins in sweep mode; otherwise lowest set debounced bit.
  always_comb begin
    w_sel_lvl = DEF_LVL;
    w_sel_idx = IDX_W'(N_SW);
    if (r_sweep_s2) begin
      for (int i = 0; i < N_SW; i++) begin
        if (r_sweep_idx == IDX_W'(i)) begin
          w_sel_lvl = w_level[i];
          w_sel_idx = IDX_W'(i);
        end
      end
    end else begin
      // Scan downwards so the lowest set index is the last assignment.
      for (int i = N_SW - 1; i >= 0; i--) begin
        if (r_sw_db[i]) begin
          w_sel_lvl = w_level[i];
          w_sel_idx = IDX_W'(i);
        end
      end
    end
  end

  // The change pulse compares levels, not indices, so equal-level steps are silent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ_out     <= '0;
      r_occ_idx     <= '0;
      r_occ_changed <= 1'b0;
    end else begin
      r_occ_out     <= w_sel_lvl;
      r_occ_idx     <= w_sel_idx;
      r_occ_changed <= (w_sel_lvl != r_occ_out);
    end
  end

  assign bus.occ_out     = r_occ_out;
  assign bus.occ_idx     = r_occ_idx;
  assign bus.occ_changed = r_occ_changed;
endmodule
